md_issue: RTL and testbench
===========================

# md_issue

Issue controller for the multiply/divide unit in the EX stage of the pipeline CPU. It decodes MIPS HI/LO and multiply/divide instructions into the 4-bit `Md_op` command, latches the operands and holds the command until the unit drops `Md_stall`. It freezes the pipeline while the operation is outstanding and returns MFHI/MFLO/MUL results as a registered write-back value.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 40: WAIT-cycle limit; used only when `MD_TIMEOUT_EN` is defined.

Ports:
- `Clk` in 1: clock; all state changes on posedge.
- `Rst` in 1: reset, asynchronous, active-high.
- `Instr_valid` in 1: EX-stage instruction valid.
- `Opcode` in 6: instruction [31:26].
- `Funct` in 6: instruction [5:0].
- `Rs_in` in 32: forwarded rs operand.
- `Rt_in` in 32: forwarded rt operand.
- `Flush` in 1: squash the EX instruction.
- `Pipe_adv` in 1: EX stage advances at this posedge.
- `Md_stall` in 1: busy indication from the multiply/divide unit.
- `Res_in` in 32: result from the multiply/divide unit.
- `Md_op` out 4: command to the multiply/divide unit (registered).
- `Md_rs` out 32: latched rs operand.
- `Md_rt` out 32: latched rt operand.
- `Md_busy` out 1: pipeline stall request.
- `Wb_en` out 1: write-back valid (MFHI/MFLO/MUL only).
- `Wb_data` out 32: write-back value.
- `Md_err` out 1: timeout flag.

## Operation
- Decode table:
  - SPECIAL (000000) funct 010000 → MFHI 0011.
  - 010001 → MTHI 0101.
  - 010010 → MFLO 0100.
  - 010011 → MTLO 0110.
  - 011000 → MULT 1000.
  - 011001 → MULTU 1001.
  - 011010 → DIV 0001.
  - 011011 → DIVU 0010.
  - SPECIAL2 (011100) funct 000010 → MUL 0111.
  - Anything else → 0000, meaning no operation.
- Write-back ops: MFHI, MFLO and MUL.
- States:
  - IDLE: `Md_op`=0000. If `Instr_valid`, decoded op ≠0000 and not `Flush`, latch op, `Rs_in` and `Rt_in`, then go to ISSUE.
  - ISSUE: drive `Md_op`. At posedge, if `Md_stall`=0, go to DONE; otherwise go to WAIT.
  - WAIT: hold `Md_op`, `Md_rs` and `Md_rt` stable. Go to DONE at the first posedge sampling `Md_stall`=0.
  - DONE: `Md_op`=0000. Stay until `Pipe_adv`, then go to IDLE.
- Result capture: on the ISSUE/WAIT→DONE edge, for write-back ops, `Wb_data`←`Res_in`. `Wb_en`=1 throughout DONE for those ops, and 0 otherwise.
- `Md_busy` is combinational:
  - 1 in IDLE when a valid non-flushed md op is decoded.
  - 1 in ISSUE and WAIT.
  - 0 in DONE.
- `Flush` in any state → IDLE at the next posedge; `Md_op`=0000 and `Wb_en`=0. Hi/Lo updates already sampled by the unit are not rolled back. The hazard unit flushes md ops only before ISSUE, except on exceptions.
- `Rst` (any state, including mid-WAIT) → IDLE. Every register is cleared:
  - `Md_op`=0000.
  - `Md_rs`=`Md_rt`=0.
  - `Wb_en`=0.
  - `Wb_data`=0.
  - `Md_err`=0.
  - Timeout counter=0.
- `Rst` takes priority over `Flush`, and `Flush` over normal transitions.

## Timing
- The multiply/divide unit samples on the negedge. `Md_op` is registered at posedge, so each command is stable for a full half-cycle before sampling.
- MT*/MF*/MULT/MULTU/MUL: IDLE → ISSUE → DONE. `Md_busy` is high for 2 cycles.
- DIV/DIVU: ISSUE, then N WAIT cycles while the unit iterates (≈33). Latency = 2+N cycles.
- `Wb_data` is valid from the first DONE cycle and stays stable until IDLE.
- Back-to-back md ops: after DONE→IDLE, the next op issues with no extra bubble.

## Configuration
- `MD_TIMEOUT_EN` defined:
  - A 6-bit counter increments in WAIT and clears on ISSUE.
  - When it reaches `TIMEOUT_CYC`: force DONE, `Wb_en`=0, set `Md_err`=1.
  - `Md_err` stays set until the next op is accepted in IDLE or `Rst`.
- `MD_TIMEOUT_EN` undefined: WAIT is unbounded, the counter is absent and `Md_err` is tied to 0.

## Structure
- Package `md_pkg` contains:
  - The `Md_op` code constants.
  - The SPECIAL/SPECIAL2 opcode and funct constants.
  - State encoding: IDLE/ISSUE/WAIT/DONE.
  - Default timeout 40.
- Sub-module `md_decode`: combinational; Opcode/Funct → {op[3:0], wb}.
- `md_issue` holds the FSM, the latches and the timeout logic.

## Test plan
- MULT: Rs=0xFFFFFFFE, Rt=3, then MFLO, then MFHI → `Wb_data` 0xFFFFFFFA, then 0xFFFFFFFF; each op has `Md_busy` high for 2 cycles.
- MUL: Rs=7, Rt=6 → `Md_op`=0111 in ISSUE; `Wb_en`=1 in DONE with `Wb_data`=0x2A.
- DIV: Rs=100, Rt=7, stub holds `Md_stall` for 33 cycles → `Md_op`/`Md_rs`/`Md_rt` stable throughout; then MFHI → 2, MFLO → 14.
- `Flush` in IDLE with DIVU decoded → no ISSUE, `Md_op` stays 0000, `Md_busy` drops the same cycle.
- `Rst` asserted mid-WAIT → all outputs reset asynchronously; a next MTHI 0x1234 followed by MFHI returns 0x1234.
- With `MD_TIMEOUT_EN`, `Md_stall` stuck at 1 → DONE after 40 WAIT cycles, `Md_err`=1 and `Wb_en`=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide issue controller: command codes,
// SPECIAL/SPECIAL2 decode constants, FSM state encoding and the default timeout.
package md_pkg;

   localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
   localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;

   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MUL   = 6'b000010;

   localparam logic [3:0] MD_NOP   = 4'b0000;
   localparam logic [3:0] MD_DIV   = 4'b0001;
   localparam logic [3:0] MD_DIVU  = 4'b0010;
   localparam logic [3:0] MD_MFHI  = 4'b0011;
   localparam logic [3:0] MD_MFLO  = 4'b0100;
   localparam logic [3:0] MD_MTHI  = 4'b0101;
   localparam logic [3:0] MD_MTLO  = 4'b0110;
   localparam logic [3:0] MD_MUL   = 4'b0111;
   localparam logic [3:0] MD_MULT  = 4'b1000;
   localparam logic [3:0] MD_MULTU = 4'b1001;

   localparam int MD_TIMEOUT_DEF = 40;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } md_state_e;

endpackage

// File: rtl/md_decode.sv
// Combinational decode of MIPS HI/LO and mul/div instructions into the 4-bit
// unit command plus a flag marking ops that return a value to the register file.
module md_decode
   import md_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output logic [3:0] o_op,
   output logic       o_wb
);

   always_comb begin
      o_op = MD_NOP;
      if (i_opcode == OPC_SPECIAL) begin
         case (i_funct)
            FN_MFHI:  o_op = MD_MFHI;
            FN_MTHI:  o_op = MD_MTHI;
            FN_MFLO:  o_op = MD_MFLO;
            FN_MTLO:  o_op = MD_MTLO;
            FN_MULT:  o_op = MD_MULT;
            FN_MULTU: o_op = MD_MULTU;
            FN_DIV:   o_op = MD_DIV;
            FN_DIVU:  o_op = MD_DIVU;
            default:  o_op = MD_NOP;
         endcase
      end else if (i_opcode == OPC_SPECIAL2 && i_funct == FN_MUL) begin
         o_op = MD_MUL;
      end
   end

   assign o_wb = (o_op == MD_MFHI) || (o_op == MD_MFLO) || (o_op == MD_MUL);

endmodule

// File: rtl/md_issue.sv
// EX-stage issue controller for the mul/div unit: IDLE/ISSUE/WAIT/DONE FSM,
// operand latches and registered write-back. Optional WAIT timeout: MD_TIMEOUT_EN.
module md_issue
   import md_pkg::*;
#(
   parameter int TIMEOUT_CYC = MD_TIMEOUT_DEF
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Instr_valid,
   input  logic [5:0]  Opcode,
   input  logic [5:0]  Funct,
   input  logic [31:0] Rs_in,
   input  logic [31:0] Rt_in,
   input  logic        Flush,
   input  logic        Pipe_adv,
   input  logic        Md_stall,
   input  logic [31:0] Res_in,
   output logic [3:0]  Md_op,
   output logic [31:0] Md_rs,
   output logic [31:0] Md_rt,
   output logic        Md_busy,
   output logic        Wb_en,
   output logic [31:0] Wb_data,
   output logic        Md_err
);

   md_state_e   r_state, w_next;
   logic [3:0]  w_dec_op;
   logic        w_dec_wb;
   logic [3:0]  r_op;
   logic        r_wb;
   logic [31:0] r_rs, r_rt, r_wb_data;
   logic        r_wb_en;
   logic        w_accept, w_complete, w_timeout;

   md_decode u_dec (
      .i_opcode (Opcode),
      .i_funct  (Funct),
      .o_op     (w_dec_op),
      .o_wb     (w_dec_wb)
   );

   assign w_accept = (r_state == ST_IDLE) && Instr_valid && (w_dec_op != MD_NOP) && !Flush;

`ifdef MD_TIMEOUT_EN
   logic [5:0] r_cnt;
   logic       r_err;

   // r_cnt holds (WAIT cycles so far - 1), so the compare fires on the last allowed WAIT cycle
   assign w_timeout = (r_state == ST_WAIT) && Md_stall && (r_cnt == 6'(TIMEOUT_CYC - 1));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == ST_ISSUE)     r_cnt <= '0;
         else if (r_state == ST_WAIT) r_cnt <= r_cnt + 6'd1;
         if (w_accept)                r_err <= 1'b0;
         else if (w_timeout && !Flush) r_err <= 1'b1;
      end
   end

   assign Md_err = r_err;
`else
   logic [5:0] w_unused_timeout;
   assign w_unused_timeout = 6'(TIMEOUT_CYC);
   assign w_timeout        = 1'b0;
   assign Md_err           = 1'b0;
`endif

   assign w_complete = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && (!Md_stall || w_timeout);

   always_comb begin
      w_next  = r_state;
      Md_busy = 1'b0;
      case (r_state)
         ST_IDLE: begin
            Md_busy = w_accept;
            if (w_accept) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            Md_busy = 1'b1;
            w_next  = Md_stall ? ST_WAIT : ST_DONE;
         end
         ST_WAIT: begin
            Md_busy = 1'b1;
            if (w_complete) w_next = ST_DONE;
         end
         ST_DONE: begin
            if (Pipe_adv) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      if (Flush) w_next = ST_IDLE;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state   <= ST_IDLE;
         r_op      <= MD_NOP;
         r_wb      <= 1'b0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_wb_en   <= 1'b0;
         r_wb_data <= '0;
      end else begin
         r_state <= w_next;
         if (Flush) begin
            r_op    <= MD_NOP;
            r_wb_en <= 1'b0;
         end else if (w_accept) begin
            r_op <= w_dec_op;
            r_wb <= w_dec_wb;
            r_rs <= Rs_in;
            r_rt <= Rt_in;
         end else if (w_complete) begin
            // a timed-out op never returns data, even if it was a write-back op
            r_op    <= MD_NOP;
            r_wb_en <= r_wb && !w_timeout;
            if (r_wb && !w_timeout) r_wb_data <= Res_in;
         end else if (r_state == ST_DONE && Pipe_adv) begin
            r_wb_en <= 1'b0;
         end
      end
   end

   assign Md_op   = r_op;
   assign Md_rs   = r_rs;
   assign Md_rt   = r_rt;
   assign Wb_en   = r_wb_en;
   assign Wb_data = r_wb_data;

endmodule

// File: tb/tb_md_issue.sv
// Bench for md_issue: a HI/LO unit stub, a transaction-level expected-output
// model checked every negedge, and directed ops with literal expectations.
module tb_md_issue;

   localparam int TO_CYC = 40;

   logic        Clk, Rst, Instr_valid, Flush, Pipe_adv, Md_stall;
   logic [5:0]  Opcode, Funct;
   logic [31:0] Rs_in, Rt_in, Res_in;
   logic [3:0]  Md_op;
   logic [31:0] Md_rs, Md_rt, Wb_data;
   logic        Md_busy, Wb_en, Md_err;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   int stall_len = 0;

   md_issue #(.TIMEOUT_CYC(TO_CYC)) dut (
      .Clk(Clk), .Rst(Rst), .Instr_valid(Instr_valid), .Opcode(Opcode), .Funct(Funct),
      .Rs_in(Rs_in), .Rt_in(Rt_in), .Flush(Flush), .Pipe_adv(Pipe_adv),
      .Md_stall(Md_stall), .Res_in(Res_in), .Md_op(Md_op), .Md_rs(Md_rs),
      .Md_rt(Md_rt), .Md_busy(Md_busy), .Wb_en(Wb_en), .Wb_data(Wb_data), .Md_err(Md_err)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_dec(input logic [5:0] opc, input logic [5:0] fn);
      if (opc == 6'b000000) begin
         case (fn)
            6'b010000: return 4'b0011;
            6'b010001: return 4'b0101;
            6'b010010: return 4'b0100;
            6'b010011: return 4'b0110;
            6'b011000: return 4'b1000;
            6'b011001: return 4'b1001;
            6'b011010: return 4'b0001;
            6'b011011: return 4'b0010;
            default:   return 4'b0000;
         endcase
      end
      if (opc == 6'b011100 && fn == 6'b000010) return 4'b0111;
      return 4'b0000;
   endfunction

   // Mul/div unit stub: samples each new command once on the negedge
   logic [31:0] hi, lo;
   bit          seen;
   int          st_left;
   always @(negedge Clk) begin
      logic [63:0] p;
      if (Rst) begin
         Md_stall <= 1'b0;
         seen     <= 1'b0;
         st_left  <= 0;
         Res_in   <= '0;
      end else if (Md_op == 4'b0000) begin
         seen     <= 1'b0;
         Md_stall <= 1'b0;
         st_left  <= 0;
      end else if (!seen) begin
         seen <= 1'b1;
         case (Md_op)
            4'b1000: begin
               p = {{32{Md_rs[31]}}, Md_rs} * {{32{Md_rt[31]}}, Md_rt};
               hi <= p[63:32]; lo <= p[31:0];
            end
            4'b1001: begin
               p = {32'b0, Md_rs} * {32'b0, Md_rt};
               hi <= p[63:32]; lo <= p[31:0];
            end
            4'b0001: if (Md_rt != 0) begin
               lo <= 32'($signed(Md_rs) / $signed(Md_rt));
               hi <= 32'($signed(Md_rs) % $signed(Md_rt));
            end
            4'b0010: if (Md_rt != 0) begin
               lo <= Md_rs / Md_rt;
               hi <= Md_rs % Md_rt;
            end
            4'b0101: hi <= Md_rs;
            4'b0110: lo <= Md_rs;
            4'b0011: Res_in <= hi;
            4'b0100: Res_in <= lo;
            4'b0111: Res_in <= Md_rs * Md_rt;
            default: ;
         endcase
         if ((Md_op == 4'b0001 || Md_op == 4'b0010) && stall_len > 0) begin
            Md_stall <= 1'b1;
            st_left  <= stall_len;
         end
      end else if (st_left > 0) begin
         st_left <= st_left - 1;
         if (st_left == 1) Md_stall <= 1'b0;
      end
   end

   // Expected-output model: one op is either outstanding, finished-awaiting-advance, or absent
   bit          m_pend, m_ready, m_wben, m_wb, m_err;
   logic [3:0]  m_op;
   logic [31:0] m_rs, m_rt, m_wbd;
   int          m_age;
   always @(posedge Clk or posedge Rst) begin
      logic [3:0] d;
      d = ref_dec(Opcode, Funct);
      if (Rst) begin
         m_pend <= 0; m_ready <= 0; m_wben <= 0; m_wb <= 0; m_err <= 0;
         m_op <= '0; m_rs <= '0; m_rt <= '0; m_wbd <= '0; m_age <= 0;
      end else if (Flush) begin
         m_pend <= 0; m_ready <= 0; m_wben <= 0;
      end else if (m_ready) begin
         if (Pipe_adv) begin
            m_ready <= 0; m_wben <= 0;
         end
      end else if (m_pend) begin
         if (!Md_stall) begin
            m_pend <= 0; m_ready <= 1; m_wben <= m_wb;
            if (m_wb) m_wbd <= Res_in;
`ifdef MD_TIMEOUT_EN
         end else if (m_age == TO_CYC) begin
            m_pend <= 0; m_ready <= 1; m_wben <= 0; m_err <= 1;
`endif
         end else begin
            m_age <= m_age + 1;
         end
      end else if (Instr_valid && d != 4'b0000) begin
         m_pend <= 1; m_age <= 0; m_op <= d; m_err <= 0;
         m_wb <= (d == 4'b0011 || d == 4'b0100 || d == 4'b0111);
         m_rs <= Rs_in; m_rt <= Rt_in;
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         logic eb;
         eb = m_pend || (!m_ready && Instr_valid && !Flush && ref_dec(Opcode, Funct) != 4'b0000);
         chk("busy", 32'(Md_busy), 32'(eb));
         chk("md_op", 32'(Md_op), m_pend ? 32'(m_op) : 32'd0);
         chk("md_rs", Md_rs, m_rs);
         chk("md_rt", Md_rt, m_rt);
         chk("wb_en", 32'(Wb_en), 32'(m_wben));
         chk("wb_data", Wb_data, m_wbd);
         chk("md_err", 32'(Md_err), 32'(m_err));
      end
   end

   // Presents one instruction until the controller reaches DONE, then advances the pipe.
   task automatic do_op(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt, input int stall,
                        input logic [3:0] exp_op, input logic exp_wb,
                        input logic [31:0] exp_data, input int exp_busy);
      int nb;
      bit done;
      nb = 0;
      done = 0;
      stall_len = stall;
      Instr_valid = 1'b1; Opcode = opc; Funct = fn; Rs_in = rs; Rt_in = rt; Pipe_adv = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge Clk);
         if (Md_busy) begin
            nb++;
            if (Md_op != 4'b0000) chk({nm, "_op"}, 32'(Md_op), 32'(exp_op));
         end else begin
            done = 1;
         end
      end
      chk({nm, "_reached_done"}, 32'(done), 32'd1);
      chk({nm, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
      chk({nm, "_wb_en"}, 32'(Wb_en), 32'(exp_wb));
      if (exp_wb) chk({nm, "_wb_data"}, Wb_data, exp_data);
      @(posedge Clk); #1;
      Instr_valid = 1'b0; Pipe_adv = 1'b1;
      @(posedge Clk); #1;
      Pipe_adv = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      Rst = 1'b1; Instr_valid = 1'b0; Flush = 1'b0; Pipe_adv = 1'b0;
      Opcode = '0; Funct = '0; Rs_in = '0; Rt_in = '0;
      #2;
      chk("rst_md_op", 32'(Md_op), 32'd0);
      chk("rst_wb_en", 32'(Wb_en), 32'd0);
      chk("rst_wb_data", Wb_data, 32'd0);
      chk("rst_busy", 32'(Md_busy), 32'd0);
      chk("rst_err", 32'(Md_err), 32'd0);
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      chk_en = 1;

      do_op("mult",  6'b000000, 6'b011000, 32'hFFFFFFFE, 32'd3, 0, 4'b1000, 1'b0, 32'h0, 2);
      do_op("mflo",  6'b000000, 6'b010010, 32'h0, 32'h0, 0, 4'b0100, 1'b1, 32'hFFFFFFFA, 2);
      do_op("mfhi",  6'b000000, 6'b010000, 32'h0, 32'h0, 0, 4'b0011, 1'b1, 32'hFFFFFFFF, 2);
      do_op("mul",   6'b011100, 6'b000010, 32'd7, 32'd6, 0, 4'b0111, 1'b1, 32'h2A, 2);
      do_op("div",   6'b000000, 6'b011010, 32'd100, 32'd7, 33, 4'b0001, 1'b0, 32'h0, 35);
      do_op("mfhi2", 6'b000000, 6'b010000, 32'h0, 32'h0, 0, 4'b0011, 1'b1, 32'd2, 2);
      do_op("mflo2", 6'b000000, 6'b010010, 32'h0, 32'h0, 0, 4'b0100, 1'b1, 32'd14, 2);

      // DIVU decoded, then flushed within the same cycle
      Instr_valid = 1'b1; Opcode = 6'b000000; Funct = 6'b011011; Rs_in = 32'd9; Rt_in = 32'd2;
      #1 chk("flush_busy_pre", 32'(Md_busy), 32'd1);
      Flush = 1'b1;
      #1 chk("flush_busy_drop", 32'(Md_busy), 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      chk("flush_no_issue", 32'(Md_op), 32'd0);
      @(posedge Clk); #1;
      Flush = 1'b0; Instr_valid = 1'b0;

      // Reset in the middle of a divide
      stall_len = 30;
      Instr_valid = 1'b1; Opcode = 6'b000000; Funct = 6'b011010; Rs_in = 32'd55; Rt_in = 32'd5;
      repeat (6) @(negedge Clk);
      chk("wait_md_op", 32'(Md_op), 32'd1);
      chk("wait_md_rs", Md_rs, 32'd55);
      #2 Rst = 1'b1; Instr_valid = 1'b0;
      #1;
      chk("arst_md_op", 32'(Md_op), 32'd0);
      chk("arst_md_rs", Md_rs, 32'd0);
      chk("arst_md_rt", Md_rt, 32'd0);
      chk("arst_wb_data", Wb_data, 32'd0);
      chk("arst_busy", 32'(Md_busy), 32'd0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      do_op("mthi",  6'b000000, 6'b010001, 32'h1234, 32'h0, 0, 4'b0101, 1'b0, 32'h0, 2);
      do_op("mfhi3", 6'b000000, 6'b010000, 32'h0, 32'h0, 0, 4'b0011, 1'b1, 32'h1234, 2);

`ifdef MD_TIMEOUT_EN
      do_op("div_to", 6'b000000, 6'b011010, 32'd100, 32'd7, 1000, 4'b0001, 1'b0, 32'h0, 2 + TO_CYC);
      chk("timeout_err", 32'(Md_err), 32'd1);
      do_op("mtlo", 6'b000000, 6'b010011, 32'h55, 32'h0, 0, 4'b0110, 1'b0, 32'h0, 2);
      chk("err_cleared", 32'(Md_err), 32'd0);
`endif

      repeat (2) @(posedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
